// File: rtl/serial_alu_seq_if.sv
// serial_alu_seq_if: request/response bundle for the bit-serial ALU sequencer.
// master = requester (drives operands and start), slave = sequencer.
interface serial_alu_seq_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic             start;
   logic [5:0]       funct;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;

   modport master (output start, funct, a, b, input busy, done, result, zero);
   modport slave  (input start, funct, a, b, output busy, done, result, zero);
endinterface

// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial sequencer around a 1-bit ALU result-select slice.
// Feeds per-bit AND/OR/full-adder/SLT candidates to the slice, LSB first, and
// shifts the selected bit back into a WIDTH-bit result register.
// Optional macro SERIAL_ALU_OVF_EN adds the signed-overflow port ovf_o.
module serial_alu_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   serial_alu_seq_if.slave   bus,
   output logic [5:0]        slice_sel_o,
   output logic              slice_and_o,
   output logic              slice_or_o,
   output logic              slice_fa_o,
   output logic              slice_slt_o,
   input  logic              slice_out_i
`ifdef SERIAL_ALU_OVF_EN
   ,
   output logic              ovf_o
`endif
);

   localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [5:0] F_ADD = 6'd32;
   localparam logic [5:0] F_SUB = 6'd34;
   localparam logic [5:0] F_AND = 6'd36;
   localparam logic [5:0] F_OR  = 6'd37;
   localparam logic [5:0] F_SLT = 6'd42;

   typedef enum logic [1:0] {IDLE, CALC, SLTFIX, DONE} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
   logic [5:0]       funct_q, funct_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             sub_q, sub_d, carry_q, carry_d, zero_q, zero_d;
   logic             sum_msb_q, sum_msb_d, vflag_q, vflag_d;
`ifdef SERIAL_ALU_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic legal, is_sub, last_bit, bit_a, bit_bp, fa, maj, less;

   assign legal    = (bus.funct == F_ADD) || (bus.funct == F_SUB) || (bus.funct == F_AND)
                  || (bus.funct == F_OR)  || (bus.funct == F_SLT);
   assign is_sub   = (bus.funct == F_SUB) || (bus.funct == F_SLT);
   assign last_bit = (idx_q == IW'(WIDTH - 1));
   assign bit_a    = a_q[idx_q];
   assign bit_bp   = b_q[idx_q] ^ sub_q;
   assign fa       = bit_a ^ bit_bp ^ carry_q;
   assign maj      = (bit_a & bit_bp) | (bit_a & carry_q) | (bit_bp & carry_q);
   // Sign of the difference corrected by signed overflow.
   assign less     = sum_msb_q ^ vflag_q;

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state decision.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = legal ? CALC : DONE;
         CALC:    if (last_bit) state_d = (funct_q == F_SLT) ? SLTFIX : DONE;
         SLTFIX:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Status and slice drive; candidates are only live while computing.
   always_comb begin
      bus.busy    = (state_q == CALC) || (state_q == SLTFIX);
      bus.done    = (state_q == DONE);
      slice_sel_o = funct_q;
      slice_and_o = 1'b0;
      slice_or_o  = 1'b0;
      slice_fa_o  = 1'b0;
      slice_slt_o = 1'b0;
      if (state_q == CALC) begin
         slice_and_o = bit_a & b_q[idx_q];
         slice_or_o  = bit_a | b_q[idx_q];
         slice_fa_o  = fa;
      end
      if (state_q == SLTFIX) slice_slt_o = less;
   end

   assign bus.result = result_q;
   assign bus.zero   = zero_q;
`ifdef SERIAL_ALU_OVF_EN
   assign ovf_o = ovf_q;
`endif

   // Datapath registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_q <= '0; b_q <= '0; funct_q <= '0; idx_q <= '0;
         sub_q <= 1'b0; carry_q <= 1'b0; result_q <= '0; zero_q <= 1'b0;
         sum_msb_q <= 1'b0; vflag_q <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
         ovf_q <= 1'b0;
`endif
      end else begin
         a_q <= a_d; b_q <= b_d; funct_q <= funct_d; idx_q <= idx_d;
         sub_q <= sub_d; carry_q <= carry_d; result_q <= result_d; zero_q <= zero_d;
         sum_msb_q <= sum_msb_d; vflag_q <= vflag_d;
`ifdef SERIAL_ALU_OVF_EN
         ovf_q <= ovf_d;
`endif
      end
   end

   // Datapath next values; zero/ovf are settled on the edge entering DONE.
   always_comb begin
      a_d = a_q; b_d = b_q; funct_d = funct_q; idx_d = idx_q;
      sub_d = sub_q; carry_d = carry_q; result_d = result_q; zero_d = zero_q;
      sum_msb_d = sum_msb_q; vflag_d = vflag_q;
`ifdef SERIAL_ALU_OVF_EN
      ovf_d = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (legal) begin
                  a_d = bus.a; b_d = bus.b; funct_d = bus.funct;
                  idx_d = '0; sub_d = is_sub; carry_d = is_sub;
               end else begin
                  result_d = '0;
                  zero_d   = 1'b1;
`ifdef SERIAL_ALU_OVF_EN
                  ovf_d    = 1'b0;
`endif
               end
            end
         end
         CALC: begin
            carry_d         = maj;
            result_d[idx_q] = slice_out_i;
            idx_d           = idx_q + IW'(1);
            if (last_bit) begin
               sum_msb_d = fa;
               vflag_d   = carry_q ^ maj;
               if (funct_q != F_SLT) begin
                  zero_d = (result_d == '0);
`ifdef SERIAL_ALU_OVF_EN
                  ovf_d  = ((funct_q == F_ADD) || (funct_q == F_SUB)) ? (carry_q ^ maj) : 1'b0;
`endif
               end
            end
         end
         SLTFIX: begin
            result_d[0] = slice_out_i;
            zero_d      = (result_d == '0);
`ifdef SERIAL_ALU_OVF_EN
            ovf_d       = 1'b0;
`endif
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_serial_alu_seq.sv
module tb_serial_alu_seq;
   localparam int unsigned W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [5:0] slice_sel;
   logic slice_and, slice_or, slice_fa, slice_slt, slice_out;
   logic ovf;
   int checks = 0;
   int errors = 0;

   serial_alu_seq_if #(.WIDTH(W)) bus ();

   serial_alu_seq #(.WIDTH(W)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus         (bus),
      .slice_sel_o (slice_sel),
      .slice_and_o (slice_and),
      .slice_or_o  (slice_or),
      .slice_fa_o  (slice_fa),
      .slice_slt_o (slice_slt),
      .slice_out_i (slice_out)
`ifdef SERIAL_ALU_OVF_EN
      ,
      .ovf_o       (ovf)
`endif
   );

`ifndef SERIAL_ALU_OVF_EN
   assign ovf = 1'b0;
`endif

   always #5 clk = ~clk;

   // 1-bit result-select slice.
   always_comb begin
      slice_out = 1'b0;
      case (slice_sel)
         6'd36:        slice_out = slice_and;
         6'd37:        slice_out = slice_or;
         6'd32, 6'd34: slice_out = slice_fa;
         6'd42:        slice_out = slice_slt;
         default:      slice_out = 1'b0;
      endcase
   end

   function automatic logic [W-1:0] ref_result(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      case (f)
         6'd32:   return a + b;
         6'd34:   return a - b;
         6'd36:   return a & b;
         6'd37:   return a | b;
         6'd42:   return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
         default: return '0;
      endcase
   endfunction

   function automatic logic ref_ovf(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      if (f == 6'd32) begin
         r = a + b;
         return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end else if (f == 6'd34) begin
         r = a - b;
         return (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      return 1'b0;
   endfunction

   function automatic int ref_cycles(input logic [5:0] f);
      if (f == 6'd42) return W + 2;
      if (f == 6'd32 || f == 6'd34 || f == 6'd36 || f == 6'd37) return W + 1;
      return 1;
   endfunction

   // Issues one operation and waits (bounded) for done; scrambles a/b after acceptance.
   task automatic do_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic z, output logic ov,
                        output int cyc, output int bcnt, output int selbad, output int overlap,
                        output bit timeout);
      res = '0; z = 1'b0; ov = 1'b0; cyc = 0; bcnt = 0; selbad = 0; overlap = 0; timeout = 1'b1;
      @(negedge clk);
      bus.start = 1'b1; bus.funct = f; bus.a = a; bus.b = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.a = $urandom(); bus.b = $urandom();
      for (int k = 1; k <= 3 * W; k++) begin
         @(negedge clk);
         if (bus.busy) begin
            bcnt++;
            if (slice_sel !== f) selbad++;
         end
         if (bus.busy && bus.done) overlap++;
         if (bus.done) begin
            cyc = k; res = bus.result; z = bus.zero; ov = ovf; timeout = 1'b0;
            break;
         end
      end
   endtask

   task automatic check_op(input string name, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] res, exp;
      logic z, ov;
      int cyc, bcnt, selbad, overlap;
      bit to;
      do_op(f, a, b, res, z, ov, cyc, bcnt, selbad, overlap, to);
      exp = ref_result(f, a, b);
      checks++;
      if (to) begin errors++; $display("FAIL %s timeout: no done within %0d cycles", name, 3 * W); return; end
      checks++;
      if (res !== exp) begin errors++; $display("FAIL %s result: got %h expected %h (f=%0d a=%h b=%h)", name, res, exp, f, a, b); end
      checks++;
      if (z !== (exp == '0)) begin errors++; $display("FAIL %s zero: got %b expected %b", name, z, (exp == '0)); end
      checks++;
      if (cyc != ref_cycles(f)) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, ref_cycles(f)); end
      checks++;
      if (bcnt != ref_cycles(f) - 1) begin errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, bcnt, ref_cycles(f) - 1); end
      checks++;
      if (selbad != 0 || overlap != 0) begin errors++; $display("FAIL %s sel/overlap: sel_mismatch=%0d busy_with_done=%0d expected 0/0", name, selbad, overlap); end
`ifdef SERIAL_ALU_OVF_EN
      checks++;
      if (ov !== ref_ovf(f, a, b)) begin errors++; $display("FAIL %s ovf: got %b expected %b", name, ov, ref_ovf(f, a, b)); end
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.start = 1'b0; bus.funct = '0; bus.a = '0; bus.b = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.zero, ovf} !== 4'b0 || bus.result !== '0)
         begin errors++; $display("FAIL reset_status: busy/done/zero/ovf=%b result=%h expected 0000/0", {bus.busy, bus.done, bus.zero, ovf}, bus.result); end
      checks++;
      if ({slice_sel, slice_and, slice_or, slice_fa, slice_slt} !== 10'b0)
         begin errors++; $display("FAIL reset_slice: got %b expected 0", {slice_sel, slice_and, slice_or, slice_fa, slice_slt}); end
   endtask

   task automatic test_directed();
      check_op("add_5_7",    6'd32, 32'd5, 32'd7);
      check_op("sub_3_5",    6'd34, 32'd3, 32'd5);
      check_op("sub_9_9",    6'd34, 32'd9, 32'd9);
      check_op("sub_ovf",    6'd34, 32'h8000_0000, 32'd1);
      check_op("add_ovf",    6'd32, 32'h7FFF_FFFF, 32'd1);
      check_op("slt_min_1",  6'd42, 32'h8000_0000, 32'd1);
      check_op("slt_5_3",    6'd42, 32'd5, 32'd3);
      check_op("slt_max_min",6'd42, 32'h7FFF_FFFF, 32'h8000_0000);
      check_op("and_pat",    6'd36, 32'hF0F0_F0F0, 32'hFF00_FF00);
      check_op("or_pat",     6'd37, 32'hF0F0_F0F0, 32'hFF00_FF00);
      check_op("illegal_3f", 6'h3F, 32'd1, 32'd2);
   endtask

   task automatic test_random();
      logic [5:0] codes [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
      logic [W-1:0] a, b;
      for (int n = 0; n < 24; n++) begin
         a = $urandom();
         b = ($urandom_range(0, 5) == 0) ? a : W'($urandom());
         check_op("random", codes[$urandom_range(0, 5)], a, b);
      end
   endtask

   task automatic test_ignore_start();
      int k;
      bit seen = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.funct = 6'd32; bus.a = 32'd5; bus.b = 32'd7;
      @(posedge clk);
      #1 bus.start = 1'b0;
      k = 0;
      while (k < 3 * W && !seen) begin
         @(negedge clk);
         k++;
         if (k == 10) begin
            bus.start = 1'b1; bus.funct = 6'd34; bus.a = 32'd100; bus.b = 32'd1;
            @(posedge clk);
            #1 bus.start = 1'b0;
         end else if (bus.done) begin
            seen = 1'b1;
         end
      end
      checks++;
      if (!seen || k != W + 1) begin errors++; $display("FAIL ignore_latency: done at %0d seen=%0d expected %0d", k, seen, W + 1); end
      checks++;
      if (bus.result !== 32'd12) begin errors++; $display("FAIL ignore_mid_result: got %h expected 0000000c", bus.result); end
      bus.start = 1'b1; bus.funct = 6'd37; bus.a = 32'hFFFF; bus.b = 32'h1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd12)
         begin errors++; $display("FAIL ignore_done_start: busy=%b done=%b result=%h expected 0/0/0000000c", bus.busy, bus.done, bus.result); end
   endtask

   task automatic test_reset_mid();
      int dones = 0, busys = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.funct = 6'd32; bus.a = 32'h1234_5678; bus.b = 32'h0FED_CBA9;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (11) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0 || bus.zero !== 1'b0)
         begin errors++; $display("FAIL reset_mid_state: busy=%b done=%b zero=%b result=%h expected 0/0/0/0", bus.busy, bus.done, bus.zero, bus.result); end
      for (int k = 0; k < W + 4; k++) begin
         if (bus.done) dones++;
         if (bus.busy) busys++;
         @(negedge clk);
      end
      checks++;
      if (dones != 0 || busys != 0) begin errors++; $display("FAIL reset_mid_abandon: dones=%0d busy_cycles=%0d expected 0/0", dones, busys); end
      check_op("after_reset_add", 6'd32, 32'd1, 32'd1);
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 4; n++) check_op("b2b_sub", 6'd34, W'($urandom()), W'($urandom()));
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
